mux_sel_sequencer: RTL

//  Upstream control stage for the 3-bit selector mux. It sweeps the mux

---
 rtl/mux_seq_pkg.sv | 17 +
 rtl/dwell_timer.sv | 43 ++++
 rtl/mux_sel_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared state encoding and constants for the mux select sequencer
package mux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NCONST_DEFAULT = 4;

  // One spare bit so the counter can hold DWELL-1 for any DWELL >= 1.
  function automatic int cnt_width(input int dwell);
    return $clog2(dwell) + 1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - per-select dwell counter with a registered expire flag
module dwell_timer
  import mux_seq_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = cnt_width(DWELL);
  localparam logic [CW-1:0] CNT_TOP = CW'(DWELL - 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_expire;

  always_comb begin
    w_count_next = r_count;
    if (clear) begin
      w_count_next = '0;
    end else if (en) begin
      w_count_next = (r_count == CNT_TOP) ? '0 : r_count + 1'b1;
    end
  end

  // expire is precomputed so it is high exactly while the counter sits at DWELL-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_expire <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_expire <= !clear && (w_count_next == CNT_TOP);
    end
  end

  assign expire = r_expire;

endmodule

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - sweeps the mux select, dwells, strobes sample and owns the key register
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int LAST   = 4,
  parameter int DWELL  = 2,
  parameter int NCONST = NCONST_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             key_we,
  input  logic [WIDTH-1:0] key_wdata,
  output logic [WIDTH-1:0] sel,
  output logic [WIDTH-1:0] key,
  output logic             sample,
  output logic             busy,
  output logic             done,
  output logic             key_conflict,
  output logic             key_err
);

  localparam logic [WIDTH-1:0] LAST_SEL = WIDTH'(LAST);
  localparam logic [WIDTH:0]   NCONST_W = (WIDTH + 1)'(NCONST);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sel;
  logic [WIDTH-1:0] w_sel_next;
  logic [WIDTH-1:0] r_key;
  logic             r_conflict;
  logic             r_busy;
  logic             r_done;
  logic             r_key_err;
  logic             w_expire;
  logic             w_clear;
  logic             w_en;
  logic             w_key_ok;
  logic             w_key_drop;
  logic             w_key_hit;

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    case (r_state)
      IDLE: begin
        w_sel_next = '0;
        if (start && !abort) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_next = IDLE;
          w_sel_next   = '0;
        end else if (w_expire) begin
          if (r_sel == LAST_SEL) begin
            w_state_next = DONE;
          end else begin
            w_sel_next = r_sel + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
        w_sel_next   = '0;
      end
      default: begin
        w_state_next = IDLE;
        w_sel_next   = '0;
      end
    endcase
  end

  // Counter is held at zero whenever the next cycle is not a RUN cycle.
  assign w_clear = (w_state_next != RUN);
  assign w_en    = (r_state == RUN);

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .en    (w_en),
    .expire(w_expire)
  );

  assign w_key_ok   = key_we && (r_state != RUN);
  assign w_key_drop = key_we && (r_state == RUN);
  assign w_key_hit  = ({1'b0, key_wdata} < NCONST_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_key      <= '1;
      r_conflict <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_key_err  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sel     <= w_sel_next;
      r_busy    <= (w_state_next == RUN);
      r_done    <= (w_state_next == DONE);
      r_key_err <= w_key_drop;
      if (w_key_ok) begin
        r_key      <= key_wdata;
        r_conflict <= w_key_hit;
      end
    end
  end

  assign sel          = r_sel;
  assign key          = r_key;
  assign sample       = w_expire;
  assign busy         = r_busy;
  assign done         = r_done;
  assign key_conflict = r_conflict;
  assign key_err      = r_key_err;

endmodule
